// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, parity types,
// legal prescale values and the majority-vote helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point oversampler: captures the line just before, at and just after
// mid-bit and presents the majority of the three captures.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_val
);

  localparam logic [PRESCALE_W-1:0] PS_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] half;
  logic [2:0]            samp_reg;

  assign half = prescale >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_reg <= '0;
    end else if (edge_cnt == half - PS_ONE) begin
      samp_reg[0] <= RX_IN;
    end else if (edge_cnt == half) begin
      samp_reg[1] <= RX_IN;
    end else if (edge_cnt == half + PS_ONE) begin
      samp_reg[2] <= RX_IN;
    end
  end

  // Valid from edge prescale/2+2 until the next bit's first capture.
  assign bit_val = majority3(samp_reg);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit qualification, LSB-first data, optional parity,
// stop-bit check, with one-cycle registered result pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [WIDTH-1:0]      P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] PS_ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] PS_TWO = PRESCALE_W'(2);

  logic [2:0]            state_reg;
  logic [PRESCALE_W-1:0] edge_reg;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic [BIT_W-1:0]      bit_reg;
  logic [WIDTH-1:0]      shift_reg;
  logic                  par_en_reg;
  logic                  par_typ_reg;
  logic                  par_mis_reg;
  logic                  bit_val;
  logic                  edge_last;
  logic                  bit_last;
  logic                  stop_decide;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .RX_IN    (RX_IN),
    .edge_cnt (edge_reg),
    .prescale (prescale_reg),
    .bit_val  (bit_val)
  );

  assign edge_last = (edge_reg == prescale_reg - PS_ONE);
  assign bit_last  = (bit_reg == BIT_W'(WIDTH - 1));
  // The edge_last term only matters for illegal tiny prescales, guaranteeing exit.
  assign stop_decide = (edge_reg == (prescale_reg >> 1) + PS_TWO) || edge_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      edge_reg     <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      prescale_reg <= '0;
      par_en_reg   <= 1'b0;
      par_typ_reg  <= 1'b0;
      par_mis_reg  <= 1'b0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (state_reg != ST_IDLE) begin
        edge_reg <= edge_last ? '0 : edge_reg + PS_ONE;
      end
      case (state_reg)
        ST_IDLE: begin
          edge_reg    <= '0;
          bit_reg     <= '0;
          par_mis_reg <= 1'b0;
          // This low cycle is edge 0 of the start bit, so counting resumes at 1.
          if (!RX_IN) begin
            state_reg    <= ST_START;
            edge_reg     <= PS_ONE;
            prescale_reg <= prescale;
            par_en_reg   <= PAR_EN;
            par_typ_reg  <= PAR_TYP;
          end
        end
        ST_START: begin
          if (edge_last) begin
            state_reg <= bit_val ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (edge_last) begin
            shift_reg <= {bit_val, shift_reg[WIDTH-1:1]};
            bit_reg   <= bit_reg + BIT_W'(1);
            if (bit_last) begin
              bit_reg   <= '0;
              state_reg <= par_en_reg ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (edge_last) begin
            par_mis_reg <= bit_val != ((^shift_reg) ^ (par_typ_reg == PAR_ODD));
            state_reg   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (stop_decide) begin
            state_reg <= ST_IDLE;
            edge_reg  <= '0;
            stp_err   <= !bit_val;
            par_err   <= par_mis_reg;
            if (bit_val && !par_mis_reg) begin
              data_valid <= 1'b1;
              P_DATA     <= shift_reg;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a whole line waveform is built up front, a
// frame-level model predicts every output cycle, then the DUT is compared cycle by cycle.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int N = 24000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd16;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, stp_err;

  uart_rx #(.WIDTH(8), .PRESCALE_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .prescale   (prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;

  // Stimulus, per cycle
  logic line_a [N];
  logic rst_a  [N];
  int   ps_a   [N];
  logic pen_a  [N];
  logic ptyp_a [N];
  // Model expectations: outputs visible after the clock edge ending each cycle
  logic       e_dv [N];
  logic       e_pe [N];
  logic       e_se [N];
  logic [7:0] e_data [N];
  logic [7:0] e_pd [N];

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pd;
  } ck_t;
  ck_t ck_q[$];

  int wp = 0;
  int n_checks = 0;
  int n_fail = 0;

  function automatic int pick_ps();
    case ($urandom % 3)
      0:       return PRESCALE_8;
      1:       return PRESCALE_16;
      default: return PRESCALE_32;
    endcase
  endfunction

  task automatic put_level(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      line_a[wp] = v;
      wp++;
    end
  endtask

  task automatic put_frame(input logic [7:0] data, input int p, input logic pe, input logic pt,
                           input logic flip, input logic stopv, input logic noisy,
                           output int t0, output int d);
    int base;
    t0 = wp;
    ps_a[wp] = p;
    pen_a[wp] = pe;
    ptyp_a[wp] = pt;
    put_level(1'b0, p);
    for (int k = 0; k < 8; k++) begin
      base = wp;
      put_level(data[k], p);
      // One disturbed sample out of three must be outvoted.
      if (noisy && ($urandom % 4 == 0))
        line_a[base + p/2 - 1 + int'($urandom_range(0, 2))] = ~data[k];
    end
    if (pe) put_level((^data) ^ pt ^ flip, p);
    put_level(stopv, p);
    d = t0 + (pe ? 10 : 9) * p + p/2 + 2;
  endtask

  function automatic logic maj(input int c);
    return (line_a[c-1] & line_a[c]) | (line_a[c-1] & line_a[c+1]) | (line_a[c] & line_a[c+1]);
  endfunction

  function automatic int first_rst(input int a, input int b);
    for (int i = a; i <= b; i++) if (rst_a[i]) return i;
    return -1;
  endfunction

  // Frame-level reference: find each start, vote each bit centre, decide the frame.
  task automatic run_model(input int n);
    int t, t0, p, h, nb, d, r;
    logic pe, pt, stp, mis;
    logic [7:0] dat, pd;
    for (int i = 0; i < n; i++) begin
      e_dv[i] = 0; e_pe[i] = 0; e_se[i] = 0; e_data[i] = 0;
    end
    t = 0;
    while (t < n) begin
      if (rst_a[t] || line_a[t]) begin
        t++;
        continue;
      end
      t0 = t; p = ps_a[t]; h = p / 2; pe = pen_a[t]; pt = ptyp_a[t];
      if (t0 + 12 * p >= n) break;
      r = first_rst(t0 + 1, t0 + p - 1);
      if (r >= 0) begin t = r; continue; end
      if (maj(t0 + h)) begin t = t0 + p; continue; end
      nb = pe ? 11 : 10;
      d = t0 + (nb - 1) * p + h + 2;
      r = first_rst(t0 + p, d);
      if (r >= 0) begin t = r; continue; end
      for (int k = 0; k < 8; k++) dat[k] = maj(t0 + (k + 1) * p + h);
      mis = pe && (maj(t0 + 9 * p + h) != ((^dat) ^ pt));
      stp = maj(t0 + (nb - 1) * p + h);
      e_se[d] = !stp;
      e_pe[d] = mis;
      if (stp && !mis) begin
        e_dv[d] = 1;
        e_data[d] = dat;
      end
      t = d + 1;
    end
    pd = 0;
    for (int i = 0; i < n; i++) begin
      if (rst_a[i]) pd = 0;
      else if (e_dv[i]) pd = e_data[i];
      e_pd[i] = pd;
    end
  endtask

  initial begin
    int t0, d, t0b, db, p, gap, nsim, shown;
    ck_t c;
    for (int i = 0; i < N; i++) begin
      line_a[i] = 1; rst_a[i] = 0; ps_a[i] = pick_ps();
      pen_a[i] = 1'($urandom); ptyp_a[i] = 1'($urandom);
    end
    for (int i = 0; i < 4; i++) rst_a[i] = 1;
    ck_q.push_back('{3, 1'b0, 1'b0, 1'b0, 8'h00});
    put_level(1, 10);

    put_frame(8'hA5, 16, 0, 0, 0, 1, 0, t0, d);
    ck_q.push_back('{t0 + 154, 1'b1, 1'b0, 1'b0, 8'hA5});
    put_level(1, 20);
    put_frame(8'h3C, 8, 1, PAR_EVEN, 0, 1, 0, t0, d);
    ck_q.push_back('{t0 + 86, 1'b1, 1'b0, 1'b0, 8'h3C});
    put_level(1, 10);
    put_frame(8'h3C, 8, 1, PAR_EVEN, 1, 1, 0, t0, d);
    ck_q.push_back('{t0 + 86, 1'b0, 1'b1, 1'b0, 8'h3C});
    put_level(1, 10);
    put_frame(8'h81, 32, 0, 0, 0, 0, 0, t0, d);
    ck_q.push_back('{t0 + 306, 1'b0, 1'b0, 1'b1, 8'h3C});
    put_level(1, 60);
    t0 = wp; ps_a[wp] = 16;
    put_level(0, 3);
    put_level(1, 40);
    ck_q.push_back('{t0 + 15, 1'b0, 1'b0, 1'b0, 8'h3C});
    put_frame(8'h55, 16, 0, 0, 0, 1, 0, t0, d);
    put_frame(8'hAA, 16, 0, 0, 0, 1, 0, t0b, db);
    ck_q.push_back('{t0 + 154, 1'b1, 1'b0, 1'b0, 8'h55});
    ck_q.push_back('{t0 + 314, 1'b1, 1'b0, 1'b0, 8'hAA});
    put_level(1, 20);
    put_frame(8'hF0, 16, 0, 0, 0, 1, 0, t0, d);
    rst_a[t0 + 88] = 1; rst_a[t0 + 89] = 1;
    ck_q.push_back('{t0 + 89, 1'b0, 1'b0, 1'b0, 8'h00});
    ck_q.push_back('{t0 + 160, 1'b0, 1'b0, 1'b0, 8'h00});
    put_level(1, 20);
    put_frame(8'h0F, 16, 0, 0, 0, 1, 0, t0, d);
    ck_q.push_back('{t0 + 154, 1'b1, 1'b0, 1'b0, 8'h0F});
    put_level(1, 20);

    while (wp < N - 1200) begin
      p = pick_ps();
      if ($urandom % 8 == 0) begin
        ps_a[wp] = p;
        put_level(0, 1 + int'($urandom % (p / 2 - 2)));
        put_level(1, p + 2);
      end
      put_frame(8'($urandom), p, 1'($urandom), 1'($urandom), ($urandom % 6 == 0),
                ($urandom % 6 != 0), 1'b1, t0, d);
      gap = ($urandom % 3 == 0) ? 0 : int'($urandom_range(1, 20));
      put_level(1, gap);
    end
    put_level(1, 200);
    nsim = wp;

    run_model(N);
    foreach (ck_q[i]) begin
      c = ck_q[i];
      n_checks++;
      if ({e_dv[c.cyc], e_pe[c.cyc], e_se[c.cyc]} != {c.dv, c.pe, c.se} || e_pd[c.cyc] != c.pd) begin
        n_fail++;
        $display("FAIL model_literal cycle %0d: model dv/pe/se/pd=%b%b%b/%h required %b%b%b/%h",
                 c.cyc, e_dv[c.cyc], e_pe[c.cyc], e_se[c.cyc], e_pd[c.cyc], c.dv, c.pe, c.se, c.pd);
      end
    end

    shown = 0;
    for (int t = 0; t < nsim; t++) begin
      @(negedge clk);
      rst = rst_a[t]; RX_IN = line_a[t]; prescale = 6'(ps_a[t]);
      PAR_EN = pen_a[t]; PAR_TYP = ptyp_a[t];
      @(posedge clk);
      #1;
      n_checks++;
      if ({data_valid, par_err, stp_err} !== {e_dv[t], e_pe[t], e_se[t]} || P_DATA !== e_pd[t]) begin
        n_fail++;
        if (shown < 30)
          $display("FAIL model_compare cycle %0d: dut dv/pe/se/pd=%b%b%b/%h expected %b%b%b/%h",
                   t, data_valid, par_err, stp_err, P_DATA, e_dv[t], e_pe[t], e_se[t], e_pd[t]);
        shown++;
      end else if (e_dv[t] || e_pe[t] || e_se[t]) begin
        $display("frame cycle %0d: dv=%b pe=%b se=%b P_DATA=%h", t, data_valid, par_err, stp_err, P_DATA);
      end
      foreach (ck_q[i]) begin
        if (ck_q[i].cyc == t) begin
          n_checks++;
          if ({data_valid, par_err, stp_err} !== {ck_q[i].dv, ck_q[i].pe, ck_q[i].se} || P_DATA !== ck_q[i].pd) begin
            n_fail++;
            $display("FAIL directed cycle %0d: dut dv/pe/se/pd=%b%b%b/%h required %b%b%b/%h",
                     t, data_valid, par_err, stp_err, P_DATA, ck_q[i].dv, ck_q[i].pe, ck_q[i].se, ck_q[i].pd);
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
